// File: rtl/free_list_pkg.sv
// Shared processor sizing used by the free list, ROB and rename stage.
package free_list_pkg;

  localparam int FL_NUM_PHYS = 64;
  localparam int FL_NUM_ARCH = 32;
  localparam int FL_PTAG_W   = 6;

  typedef logic [FL_PTAG_W-1:0] ptag_t;

endpackage : free_list_pkg

// File: rtl/free_list.sv
// Physical register free list: circular FIFO of tags with a speculative head,
// a retired head for mispredict recovery and a tail fed by ROB commits.
module free_list
  import free_list_pkg::*;
#(
  parameter int NUM_PHYS = FL_NUM_PHYS,
  parameter int NUM_ARCH = FL_NUM_ARCH,
  parameter int PTAG_W   = FL_PTAG_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PTAG_W-1:0] alloc_map,
  input  logic              free_flag,
  input  logic [PTAG_W-1:0] free_map,
  input  logic              flush,
  output logic [PTAG_W-1:0] free_count,
  output logic              overflow_err
);

  localparam int DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTAG_W-1:0] entry [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  retire_head;

  logic [PTR_W-1:0]  count;
  logic              full;
  logic              free_req;
  logic              push;
  logic              pop;
  logic [PTR_W-1:0]  tail_nxt;
  logic [PTR_W-1:0]  retire_nxt;
  logic [PTR_W-1:0]  head_nxt;

  // The wrap bit makes tail-head span 0..DEPTH, so full and empty differ.
  assign count       = tail - head;
  assign full        = (count == PTR_W'(DEPTH));
  assign free_count  = PTAG_W'(count);
  assign alloc_valid = (count != '0);
  assign alloc_map   = entry[head[IDX_W-1:0]];

  // p0 is the hardwired zero register and never re-enters the list.
  assign free_req = free_flag && (free_map != '0);
  assign push     = free_req && !full;
  assign pop      = alloc_req && alloc_valid && !flush;

  assign tail_nxt   = push ? tail + 1'b1 : tail;
  assign retire_nxt = push ? retire_head + 1'b1 : retire_head;
  assign head_nxt   = flush ? retire_nxt : (pop ? head + 1'b1 : head);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry[i] <= PTAG_W'(NUM_ARCH + i);
      end
      head         <= '0;
      retire_head  <= '0;
      tail         <= PTR_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      if (push) begin
        entry[tail[IDX_W-1:0]] <= free_map;
      end
      head        <= head_nxt;
      tail        <= tail_nxt;
      retire_head <= retire_nxt;
      if (free_req && full) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule : free_list

// File: tb/tb_free_list.sv
// Directed bench for free_list with a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_free_list;

  logic       CLK;
  logic       RESET;
  logic       alloc_req;
  logic       alloc_valid;
  logic [5:0] alloc_map;
  logic       free_flag;
  logic [5:0] free_map;
  logic       flush;
  logic [5:0] free_count;
  logic       overflow_err;

  int nchk = 0;
  int nerr = 0;

  free_list dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .alloc_req   (alloc_req),
    .alloc_valid (alloc_valid),
    .alloc_map   (alloc_map),
    .free_flag   (free_flag),
    .free_map    (free_map),
    .flush       (flush),
    .free_count  (free_count),
    .overflow_err(overflow_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: every tag ever placed in the list, in order, with unbounded
  // indices for the speculative head, retired head and tail.
  int seq[$];
  int m_hd, m_rt, m_tl;
  bit m_ovf;
  bit armed = 0;
  bit m_push, m_pop;

  always @(posedge CLK) begin
    if (RESET) begin
      seq.delete();
      for (int i = 0; i < 32; i++) seq.push_back(32 + i);
      m_hd  = 0;
      m_rt  = 0;
      m_tl  = 32;
      m_ovf = 0;
      armed = 1;
    end else if (armed) begin
      m_push = 0;
      if (free_flag && free_map != 0) begin
        if (m_tl - m_hd == 32) m_ovf = 1;
        else m_push = 1;
      end
      m_pop = alloc_req && !flush && (m_tl - m_hd > 0);
      if (m_push) begin
        seq.push_back(int'(free_map));
        m_tl++;
        m_rt++;
      end
      if (flush) m_hd = m_rt;
      else if (m_pop) m_hd++;
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("cyc_free_count", int'(free_count), m_tl - m_hd);
      chk("cyc_alloc_valid", int'(alloc_valid), (m_tl - m_hd > 0) ? 1 : 0);
      chk("cyc_overflow_err", int'(overflow_err), int'(m_ovf));
      if (m_tl - m_hd > 0) chk("cyc_alloc_map", int'(alloc_map), seq[m_hd]);
    end
  end

  task automatic step(input bit ar, input bit ff, input int fm, input bit fl);
    alloc_req = ar;
    free_flag = ff;
    free_map  = 6'(fm);
    flush     = fl;
    @(posedge CLK);
    #1;
    alloc_req = 1'b0;
    free_flag = 1'b0;
    free_map  = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    RESET     = 1'b0;
    alloc_req = 1'b0;
    free_flag = 1'b0;
    free_map  = '0;
    flush     = 1'b0;
  endtask

  initial begin
    RESET     = 1'b1;
    alloc_req = 1'b0;
    free_flag = 1'b0;
    free_map  = '0;
    flush     = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();
    chk("rst_alloc_valid", int'(alloc_valid), 1);
    chk("rst_alloc_map", int'(alloc_map), 32);
    chk("rst_free_count", int'(free_count), 32);
    chk("rst_overflow_err", int'(overflow_err), 0);

    // Drain all 32 tags in order, then one extra alloc is ignored.
    for (int i = 0; i < 32; i++) begin
      chk("drain_map", int'(alloc_map), 32 + i);
      step(1, 0, 0, 0);
    end
    chk("empty_valid", int'(alloc_valid), 0);
    chk("empty_count", int'(free_count), 0);
    step(1, 0, 0, 0);
    chk("extra_alloc_count", int'(free_count), 0);
    chk("extra_alloc_valid", int'(alloc_valid), 0);

    // Free into an empty list: visible only after the edge.
    free_flag = 1'b1;
    free_map  = 6'd40;
    #1;
    chk("no_bypass_valid", int'(alloc_valid), 0);
    @(posedge CLK);
    #1;
    free_flag = 1'b0;
    free_map  = '0;
    chk("refill_valid", int'(alloc_valid), 1);
    chk("refill_map", int'(alloc_map), 40);

    // 5 allocs, 2 frees, flush restores head to the retired head.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 1, 7, 0);
    step(0, 1, 9, 0);
    chk("pre_flush_count", int'(free_count), 29);
    step(0, 0, 0, 1);
    chk("flush_count", int'(free_count), 32);
    chk("flush_map", int'(alloc_map), 34);

    // Same-cycle alloc and free at count 10.
    do_reset();
    for (int i = 0; i < 22; i++) step(1, 0, 0, 0);
    chk("cnt10_before", int'(free_count), 10);
    step(1, 1, 5, 0);
    chk("cnt10_after", int'(free_count), 10);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0);
    chk("tail_append_count", int'(free_count), 1);
    chk("tail_append_map", int'(alloc_map), 5);

    // p0 free ignored; push at full sets a sticky overflow.
    do_reset();
    step(0, 1, 0, 0);
    chk("p0_count", int'(free_count), 32);
    chk("p0_map", int'(alloc_map), 32);
    chk("p0_ovf", int'(overflow_err), 0);
    step(0, 1, 5, 0);
    chk("ovf_set", int'(overflow_err), 1);
    chk("ovf_count", int'(free_count), 32);
    chk("ovf_map", int'(alloc_map), 32);
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("ovf_sticky", int'(overflow_err), 1);
    chk("ovf_sticky_count", int'(free_count), 31);
    do_reset();
    chk("ovf_cleared", int'(overflow_err), 0);

    // Flush with a same-cycle push and ignored alloc.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 11, 1);
    chk("flush_push_count", int'(free_count), 32);
    chk("flush_push_map", int'(alloc_map), 33);
    step(1, 0, 0, 0);
    chk("post_flush_map", int'(alloc_map), 34);
    chk("post_flush_count", int'(free_count), 31);

    // Reset mid-stream after 7 allocs, with requests still asserted.
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    chk("mid_map", int'(alloc_map), 39);
    alloc_req = 1'b1;
    free_flag = 1'b1;
    free_map  = 6'd3;
    flush     = 1'b1;
    do_reset();
    chk("mid_rst_map", int'(alloc_map), 32);
    chk("mid_rst_count", int'(free_count), 32);
    chk("mid_rst_valid", int'(alloc_valid), 1);
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_free_list

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 64, giving the physical register count.
REQ-002 SHALL have parameter NUM_ARCH, default 32, giving the architectural register count; list depth = NUM_PHYS-NUM_ARCH = 32.
REQ-003 SHALL have parameter PTAG_W, default 6, giving the physical tag width.
REQ-004 SHALL have port CLK, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port alloc_req, input, 1: rename consumes the head tag this cycle.
REQ-007 SHALL have port alloc_valid, output, 1: list non-empty; alloc_map is usable.
REQ-008 SHALL have port alloc_map, output, PTAG_W: tag at the head.
REQ-009 SHALL have port free_flag, input, 1: ROB committed a register-writing instruction.
REQ-010 SHALL have port free_map, input, PTAG_W: the old mapping released by that commit (ROB rename_free_reg).
REQ-011 SHALL have port flush, input, 1: mispredict recovery; restores the speculative head to the retired head.
REQ-012 SHALL have port free_count, output, PTAG_W: entries currently free, range 0..32.
REQ-013 SHALL have port overflow_err, output, 1: sticky error flag.

Function
REQ-014 SHALL be a circular FIFO of 32 PTAG_W-bit entries with head, tail and retire_head pointers, each 6 bits (5-bit index plus wrap bit).
REQ-015 SHALL drive alloc_valid, alloc_map and free_count combinationally from registered state only; there is no same-cycle bypass of free_map to alloc_map.
REQ-016 SHALL treat alloc_req with alloc_valid=1 and flush=0 as a pop: head+1. alloc_req with alloc_valid=0 SHALL be ignored.
REQ-017 SHALL treat free_flag=1 with free_map!=0 as a push: entry[tail]<=free_map, tail+1, retire_head+1.
REQ-018 SHALL ignore free_flag=1 with free_map==0 (p0 is the hardwired zero register) and leave all pointers unchanged.
REQ-019 SHALL, when a push arrives at free_count==32, drop the push, leave the pointers unchanged and set overflow_err=1 until RESET.
REQ-020 SHALL compute free_count = tail-head, modulo 64, 6-bit.
REQ-021 SHALL process alloc and free in the same cycle independently; net free_count is unchanged.
REQ-022 SHALL, on flush=1, set head <= retire_head next-state, including any push accepted in the same cycle; any alloc_req that cycle is ignored.
REQ-023 SHALL return, in the cycle after flush, free_count = tail_next - retire_head_next.
REQ-024 SHALL wrap pointer indices modulo 32; the wrap bit distinguishes full from empty.

Reset
REQ-025 SHALL, while RESET=1, load entry[i] <= NUM_ARCH+i (32..63), head=0, retire_head=0, tail=32 (wrap bit set), overflow_err=0; RESET overrides flush, alloc_req and free_flag.
REQ-026 SHALL present alloc_valid=1, alloc_map=32, free_count=32, overflow_err=0 in the first cycle after RESET deasserts.
REQ-027 SHALL discard all in-flight allocations when RESET is asserted mid-operation; the state SHALL equal the post-reset state exactly.

Structure
REQ-028 SHALL take NUM_PHYS, NUM_ARCH and PTAG_W defaults from the shared processor package, which the ROB and rename stage also use.
REQ-029 SHALL be a single module with no sub-module; the pointer arithmetic is inline.

Verification
REQ-030 SHALL cover: RESET, then 32 consecutive alloc_req -> alloc_map 32..63 in order, then alloc_valid=0 and free_count=0; a 33rd alloc_req is ignored.
REQ-031 SHALL cover: on an empty list, free_flag with free_map=40 -> alloc_valid=1 and alloc_map=40 in the next cycle, not the same cycle.
REQ-032 SHALL cover: 5 allocs, 2 frees (maps 7, 9), then flush -> free_count=32 and alloc_map=32+2=34 (retire_head advanced by 2).
REQ-033 SHALL cover: a same-cycle alloc and free at free_count=10 -> free_count stays 10 and the freed tag is appended at the tail.
REQ-034 SHALL cover: free_flag with free_map=0 -> no change; a push at free_count=32 -> overflow_err=1, held until RESET.
REQ-035 SHALL cover: RESET asserted mid-stream after 7 allocs -> alloc_map=32 and free_count=32 in the next cycle.
